// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct values,
// FSM state encoding, ALU operation encoding and trap causes.
package mips_mc_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // FSM states; the encoding is visible on dbg_state
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Why the core entered TRAP (kept internally for waveform debug)
  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
  localparam logic [1:0] TRAP_MISALIGN = 2'd2;

  // 32-bit wraparound ALU; slt compares signed
  function automatic logic [31:0] alu_eval(input alu_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

  // True for every opcode/funct combination the core implements
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    if (op == OP_RTYPE) begin
      ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
    end else begin
      ok = (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    end
    return ok;
  endfunction

endpackage

// File: rtl/mc_reg_file.sv
// GPR file: two asynchronous read ports, one synchronous write port.
// r0 and any index >= NUM_REGS read as zero; writes to them are dropped.
module mc_reg_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  // Full 32-entry view so unimplemented indices simply decode to zero
  logic [31:0] w_regs [0:31];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0 || gi >= NUM_REGS) begin : g_zero
        assign w_regs[gi] = 32'd0;
      end else begin : g_live
        logic [31:0] r_q;
        // Per-register write with asynchronous clear
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= '0;
          end else if (i_we && (i_waddr == 5'(gi))) begin
            r_q <= i_wdata;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  assign o_rdata1 = w_regs[i_raddr1];
  assign o_rdata2 = w_regs[i_raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FSM controller plus IR/MDR/A/B/ALUOut datapath
// sharing one req/ready memory port for fetch, load and store.
// Optional performance counters are compiled in with MIPS_MC_PERF_COUNTERS_EN.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              trap,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [2:0]        dbg_state
`ifdef MIPS_MC_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
`endif
);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_plus4, w_br_target, w_jump_pc;
  logic [31:0]       r_ir, r_mdr, r_a, r_b, r_alu_out;
  logic [1:0]        r_trap_cause, w_trap_cause_next;
  logic              r_run;
  logic              w_pc_we, w_ir_we, w_mdr_we, w_ab_we, w_alu_we, w_rf_we;
  logic [4:0]        w_rf_waddr;
  logic [31:0]       w_rf_wdata;

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic [25:0]       w_target;
  logic [31:0]       w_imm_sext, w_br_off, w_rs_data, w_rt_data, w_alu_b, w_alu_res;
  alu_op_t           w_alu_op;
  logic              w_legal;
  logic              w_unused;

  // Instruction field decode
  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_target   = r_ir[25:0];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_br_off   = {w_imm_sext[29:0], 2'b00};
  assign w_legal    = is_legal(w_op, w_funct);

  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  assign w_br_target = r_pc + w_br_off[ADDR_W-1:0];

  // Jump keeps the PC segment bits above bit 27 when the address is wide enough
  generate
    if (ADDR_W > 28) begin : g_jseg
      assign w_jump_pc = {r_pc[ADDR_W-1:28], w_target, 2'b00};
    end else begin : g_jnoseg
      assign w_jump_pc = {w_target, 2'b00};
    end
  endgenerate

  // ALU operation select: R-type by funct, everything else adds
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_SUB:  w_alu_op = ALU_SUB;
        FN_AND:  w_alu_op = ALU_AND;
        FN_OR:   w_alu_op = ALU_OR;
        FN_SLT:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end

  assign w_alu_b   = (w_op == OP_RTYPE) ? r_b : w_imm_sext;
  assign w_alu_res = alu_eval(w_alu_op, r_a, w_alu_b);

  mc_reg_file #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata),
    .o_rdata1 (w_rs_data),
    .o_rdata2 (w_rt_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_next;
  end

  // Next-state, datapath strobes and memory port drive
  always_comb begin
    w_state_next      = r_state;
    w_pc_we           = 1'b0;
    w_pc_next         = r_pc;
    w_ir_we           = 1'b0;
    w_mdr_we          = 1'b0;
    w_ab_we           = 1'b0;
    w_alu_we          = 1'b0;
    w_rf_we           = 1'b0;
    w_rf_waddr        = w_rd;
    w_rf_wdata        = r_alu_out;
    w_trap_cause_next = r_trap_cause;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    case (r_state)
      ST_FETCH: begin
        // r_run holds off the first request until a clock after reset release
        if (r_run) begin
          mem_req  = 1'b1;
          mem_addr = r_pc;
          if (mem_ready) begin
            w_ir_we      = 1'b1;
            w_pc_we      = 1'b1;
            w_pc_next    = w_pc_plus4;
            w_state_next = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        w_ab_we = 1'b1;
        if (!w_legal) begin
          w_trap_cause_next = TRAP_ILLEGAL;
          w_state_next      = ST_TRAP;
        end else if (w_op == OP_J || w_op == OP_JAL) begin
          w_pc_we      = 1'b1;
          w_pc_next    = w_jump_pc;
          w_state_next = ST_FETCH;
          if (w_op == OP_JAL) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = 5'd31;
            w_rf_wdata = 32'(r_pc);
          end
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (w_op)
          OP_RTYPE: begin
            if (w_funct == FN_JR) begin
              if (r_a[1:0] != 2'b00) begin
                w_trap_cause_next = TRAP_MISALIGN;
                w_state_next      = ST_TRAP;
              end else begin
                w_pc_we      = 1'b1;
                w_pc_next    = r_a[ADDR_W-1:0];
                w_state_next = ST_FETCH;
              end
            end else begin
              w_alu_we     = 1'b1;
              w_state_next = ST_WB;
            end
          end
          OP_ADDI: begin
            w_alu_we     = 1'b1;
            w_state_next = ST_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_we = 1'b1;
            if (w_alu_res[1:0] != 2'b00) begin
              w_trap_cause_next = TRAP_MISALIGN;
              w_state_next      = ST_TRAP;
            end else begin
              w_state_next = ST_MEM;
            end
          end
          OP_BEQ: begin
            if (r_a == r_b) begin
              w_pc_we   = 1'b1;
              w_pc_next = w_br_target;
            end
            w_state_next = ST_FETCH;
          end
          default: begin
            w_trap_cause_next = TRAP_ILLEGAL;
            w_state_next      = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = r_alu_out[ADDR_W-1:0];
        if (w_op == OP_SW) begin
          mem_we    = 1'b1;
          mem_wdata = r_b;
        end
        if (mem_ready) begin
          if (w_op == OP_LW) begin
            w_mdr_we     = 1'b1;
            w_state_next = ST_WB;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        w_rf_we = 1'b1;
        if (w_op == OP_RTYPE) begin
          w_rf_waddr = w_rd;
          w_rf_wdata = r_alu_out;
        end else if (w_op == OP_ADDI) begin
          w_rf_waddr = w_rt;
          w_rf_wdata = r_alu_out;
        end else begin
          w_rf_waddr = w_rt;
          w_rf_wdata = r_mdr;
        end
        w_state_next = ST_FETCH;
      end
      ST_TRAP: begin
        w_state_next = ST_TRAP;
      end
      default: begin
        w_state_next = ST_TRAP;
      end
    endcase
  end

  // Datapath holding registers and PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC[ADDR_W-1:0];
      r_ir         <= '0;
      r_mdr        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_out    <= '0;
      r_trap_cause <= TRAP_NONE;
      r_run        <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_trap_cause <= w_trap_cause_next;
      if (w_pc_we)  r_pc      <= w_pc_next;
      if (w_ir_we)  r_ir      <= mem_rdata;
      if (w_mdr_we) r_mdr     <= mem_rdata;
      if (w_alu_we) r_alu_out <= w_alu_res;
      if (w_ab_we) begin
        r_a <= w_rs_data;
        r_b <= w_rt_data;
      end
    end
  end

  assign trap      = (r_state == ST_TRAP);
  assign dbg_pc    = r_pc;
  assign dbg_state = r_state;

  // Bits only partly consumed (shamt, high address bits, cause kept for debug)
  assign w_unused = ^{r_ir[10:6], r_a, r_alu_out, r_trap_cause};

`ifdef MIPS_MC_PERF_COUNTERS_EN
  logic [31:0] r_perf_cycles, r_perf_retired;
  logic        w_retire;

  assign w_retire = (w_state_next == ST_FETCH) &&
                    ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                     (r_state == ST_MEM)    || (r_state == ST_WB));

  // Free-running cycle and retired-instruction counters, frozen in TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles  <= '0;
      r_perf_retired <= '0;
    end else begin
      if (r_state != ST_TRAP) r_perf_cycles  <= r_perf_cycles + 32'd1;
      if (w_retire)           r_perf_retired <= r_perf_retired + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_retired = r_perf_retired;
`endif

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the team's single-cycle MIPS datapath.
- Datapath and FSM controller are in one block, with IR/MDR/A/B/ALUOut holding registers.
- One shared instruction/data memory port uses a req/ready handshake, so variable-latency memory is tolerated.
- Sits between the testbench/SoC memory model and nothing else; it is a self-contained CPU core.

Parameters:
- ADDR_W, 32: PC and memory address width; legal range 28..32.
- RESET_PC, 0: PC value loaded on reset; must be word aligned.
- NUM_REGS, 32: implemented GPRs (8..32); writes to index >= NUM_REGS are dropped; reads of such an index return 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = store, 0 = load or fetch
- mem_addr  out  ADDR_W  byte address, always word aligned
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  transfer completes on a rising edge where mem_req=1 and mem_ready=1
- trap  out  1  sticky; set on illegal opcode/funct or misaligned access
- dbg_pc  out  ADDR_W  current PC
- dbg_state  out  3  FSM state encoding

Behaviour:
- Reset (async): PC=RESET_PC, state=FETCH, all GPRs=0, IR/MDR/A/B/ALUOut=0, trap=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- First mem_req rises in the first cycle after rst deasserts.
- Supported ISA: R-type add/sub/and/or/slt/jr; addi, lw, sw, beq, j, jal. Arithmetic is 32-bit two's-complement wraparound; no overflow exception. slt is signed.
- r0 reads 0 and ignores writes.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req drops in the cycle after acceptance. mem_ready while mem_req=0 is ignored.
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: req at addr=PC. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
- DECODE: A<=rf[rs], B<=rf[rt].
  - Illegal opcode or funct -> TRAP.
  - j: PC<={PC[ADDR_W-1:28], target, 2'b00} -> FETCH.
  - jal: same, plus r31<=PC (already +4) -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: ALUOut<=A op B -> WB.
  - addi: ALUOut<=A+sext(imm) -> WB.
  - lw/sw: ALUOut<=A+sext(imm). If ALUOut[1:0]!=0 -> TRAP, else -> MEM.
  - beq: if A==B, PC<=PC+(sext(imm)<<2); -> FETCH.
  - jr: if A[1:0]!=0 -> TRAP, else PC<=A -> FETCH.
- MEM:
  - lw: read ALUOut; on ready MDR<=rdata -> WB.
  - sw: write B at ALUOut; on ready -> FETCH.
- WB: rf[rd] for R-type, rf[rt] for addi; MDR into rf[rt] for lw. -> FETCH.
- TRAP: terminal. trap=1, mem_req=0, PC frozen. Only rst exits.
- Latency with mem_ready tied high:
  - j/jal: 2 cycles
  - beq/jr: 3 cycles
  - R-type/addi/sw: 4 cycles
  - lw: 5 cycles
  - Each cycle of ready=0 adds one cycle.
- Reset mid-request: mem_req drops immediately (async); any pending store is abandoned.

Optional Feature:
- Macro: MIPS_MC_PERF_COUNTERS_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_retired[31:0].
  - Both reset to 0 and wrap at 2^32.
  - perf_cycles increments every non-TRAP cycle.
  - perf_retired increments on the last cycle of each instruction (FETCH entered from DECODE/EXEC/MEM/WB).
- Undefined: the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- Package mips_mc_pkg: opcode/funct localparams, state encoding, ALU-op encoding, TRAP cause constants.
- Sub-module mc_reg_file: parametrised by NUM_REGS; 2 async read ports, 1 sync write port, r0 hardwired to 0, async reset to 0.

Test Plan:
- Zero-wait memory, program "addi r1,r0,5; addi r2,r0,7; add r3,r1,r2" -> r3=12; the third instruction's WB occurs in cycle 12 after reset release.
- sw r3,8(r0) then lw r4,8(r0), with ready held low for 3 cycles per access -> mem_we=1, addr=8, wdata=12 held stable until accepted; r4=12.
- beq r1,r1,-1 -> PC loops at the same address; taken branch costs 3 cycles per iteration; with unequal operands, PC advances by 4.
- jal to 0x40 at PC=0x10 -> r31=0x14, PC=0x40; then jr r31 -> PC=0x14.
- lw r5,2(r0) -> trap=1 after EXEC, mem_req stays 0, dbg_state=5; opcode 0x3F -> trap; rst then clears trap and PC=RESET_PC.
- NUM_REGS=8: addi r9,r0,1 then add r1,r9,r0 -> r1=0.
